// File: rtl/muldiv_unit.sv
// muldiv_unit: multi-cycle RV32M multiply/divide unit with a valid/ready handshake.
// It processes one bit per cycle: shift-add for multiplies and restoring division for divides.
// A FIX cycle applies sign correction and registers the result.
// Divide-by-zero and signed-overflow cases skip CALC and go through FIX alone.
module muldiv_unit #(
   parameter int XLEN  = 32,
   parameter int CNT_W = $clog2(XLEN) + 1
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic            flush,
   input  logic            in_valid,
   output logic            in_ready,
   input  logic [2:0]      op,
   input  logic [XLEN-1:0] a,
   input  logic [XLEN-1:0] b,
   output logic            out_valid,
   input  logic            out_ready,
   output logic [XLEN-1:0] result,
   output logic            div_by_zero
);

   localparam int AW = 2 * XLEN + 1;

   localparam logic [2:0] OP_MUL    = 3'b000;
   localparam logic [2:0] OP_MULH   = 3'b001;
   localparam logic [2:0] OP_MULHSU = 3'b010;
   localparam logic [2:0] OP_MULHU  = 3'b011;
   localparam logic [2:0] OP_DIV    = 3'b100;
   localparam logic [2:0] OP_DIVU   = 3'b101;
   localparam logic [2:0] OP_REM    = 3'b110;
   localparam logic [2:0] OP_REMU   = 3'b111;

   localparam logic [XLEN-1:0] ZERO    = {XLEN{1'b0}};
   localparam logic [XLEN-1:0] ONES    = {XLEN{1'b1}};
   localparam logic [XLEN-1:0] MIN_NEG = {1'b1, {(XLEN-1){1'b0}}};

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_CALC = 2'd1,
      S_FIX  = 2'd2,
      S_DONE = 2'd3
   } state_t;

   state_t            state_r, state_nxt_s;
   logic [CNT_W-1:0]  cnt_r;
   logic [AW-1:0]     acc_r;
   logic [XLEN-1:0]   opb_r;
   logic [2:0]        op_r;
   logic              neg_r, rem_neg_r, special_r, dbz_r;
   logic [XLEN-1:0]   result_r;
   logic              div_by_zero_r;

   logic              accept_s;
   logic              a_signed_s, b_signed_s, a_neg_s, b_neg_s;
   logic [XLEN-1:0]   abs_a_s, abs_b_s, special_val_s;
   logic              dbz_s, ovf_s, special_s;
   logic [XLEN:0]     mul_sum_s, div_trial_s;
   logic [AW-1:0]     mul_next_s, div_shift_s, div_next_s;
   logic [2*XLEN-1:0] prod_fix_s;
   logic [XLEN-1:0]   quo_fix_s, rem_fix_s, fix_val_s;

   assign accept_s    = in_valid & (state_r == S_IDLE) & ~flush;
   assign result      = result_r;
   assign div_by_zero = div_by_zero_r;

   // Operand decode: signedness, magnitudes and special-case detection.
   always_comb begin
      a_signed_s = 1'b0;
      b_signed_s = 1'b0;
      case (op)
         OP_MULH, OP_DIV, OP_REM: begin
            a_signed_s = 1'b1;
            b_signed_s = 1'b1;
         end
         OP_MULHSU: begin
            a_signed_s = 1'b1;
            b_signed_s = 1'b0;
         end
         default: begin
            a_signed_s = 1'b0;
            b_signed_s = 1'b0;
         end
      endcase
      a_neg_s = a_signed_s & a[XLEN-1];
      b_neg_s = b_signed_s & b[XLEN-1];
      if (a_neg_s) abs_a_s = ZERO - a;
      else         abs_a_s = a;
      if (b_neg_s) abs_b_s = ZERO - b;
      else         abs_b_s = b;
      dbz_s     = op[2] & (b == ZERO);
      ovf_s     = ((op == OP_DIV) || (op == OP_REM)) && (a == MIN_NEG) && (b == ONES);
      special_s = dbz_s | ovf_s;
      if (dbz_s)      special_val_s = op[1] ? a : ONES;
      else if (ovf_s) special_val_s = op[1] ? ZERO : a;
      else            special_val_s = ZERO;
   end

   // One iteration step: shift-add multiply and restoring shift-subtract divide.
   always_comb begin
      mul_sum_s   = acc_r[AW-1:XLEN] + (acc_r[0] ? {1'b0, opb_r} : {(XLEN+1){1'b0}});
      mul_next_s  = {1'b0, mul_sum_s, acc_r[XLEN-1:1]};
      div_shift_s = {acc_r[AW-2:0], 1'b0};
      div_trial_s = div_shift_s[AW-1:XLEN] - {1'b0, opb_r};
      if (div_shift_s[AW-1:XLEN] >= {1'b0, opb_r})
         div_next_s = {div_trial_s, div_shift_s[XLEN-1:1], 1'b1};
      else
         div_next_s = div_shift_s;
   end

   // Sign correction and selection of the final value.
   always_comb begin
      if (neg_r) prod_fix_s = {(2*XLEN){1'b0}} - acc_r[2*XLEN-1:0];
      else       prod_fix_s = acc_r[2*XLEN-1:0];
      if (neg_r) quo_fix_s = ZERO - acc_r[XLEN-1:0];
      else       quo_fix_s = acc_r[XLEN-1:0];
      if (rem_neg_r) rem_fix_s = ZERO - acc_r[2*XLEN-1:XLEN];
      else           rem_fix_s = acc_r[2*XLEN-1:XLEN];
      if (special_r) begin
         fix_val_s = acc_r[XLEN-1:0];
      end else begin
         case (op_r)
            OP_MUL:                      fix_val_s = prod_fix_s[XLEN-1:0];
            OP_MULH, OP_MULHSU, OP_MULHU: fix_val_s = prod_fix_s[2*XLEN-1:XLEN];
            OP_DIV, OP_DIVU:             fix_val_s = quo_fix_s;
            OP_REM, OP_REMU:             fix_val_s = rem_fix_s;
            default:                     fix_val_s = ZERO;
         endcase
      end
   end

   // State register.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state_r <= S_IDLE;
      else        state_r <= state_nxt_s;
   end

   // Next-state logic; flush overrides every transition.
   always_comb begin
      state_nxt_s = state_r;
      if (flush) begin
         state_nxt_s = S_IDLE;
      end else begin
         case (state_r)
            S_IDLE: begin
               if (accept_s) state_nxt_s = special_s ? S_FIX : S_CALC;
               else          state_nxt_s = S_IDLE;
            end
            S_CALC: begin
               if (cnt_r == CNT_W'(1)) state_nxt_s = S_FIX;
               else                    state_nxt_s = S_CALC;
            end
            S_FIX:  state_nxt_s = S_DONE;
            S_DONE: begin
               if (out_ready) state_nxt_s = S_IDLE;
               else           state_nxt_s = S_DONE;
            end
            default: state_nxt_s = S_IDLE;
         endcase
      end
   end

   // Handshake outputs decoded from the state register.
   always_comb begin
      in_ready  = (state_r == S_IDLE);
      out_valid = (state_r == S_DONE);
   end

   // Datapath: operand capture, iteration, and result registration.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt_r         <= {CNT_W{1'b0}};
         acc_r         <= {AW{1'b0}};
         opb_r         <= ZERO;
         op_r          <= 3'b000;
         neg_r         <= 1'b0;
         rem_neg_r     <= 1'b0;
         special_r     <= 1'b0;
         dbz_r         <= 1'b0;
         result_r      <= ZERO;
         div_by_zero_r <= 1'b0;
      end else begin
         case (state_r)
            S_IDLE: begin
               if (accept_s) begin
                  op_r      <= op;
                  opb_r     <= abs_b_s;
                  neg_r     <= a_neg_s ^ b_neg_s;
                  rem_neg_r <= a_neg_s;
                  special_r <= special_s;
                  dbz_r     <= dbz_s;
                  acc_r     <= {{(XLEN+1){1'b0}}, (special_s ? special_val_s : abs_a_s)};
                  cnt_r     <= special_s ? {CNT_W{1'b0}} : CNT_W'(XLEN);
               end
            end
            S_CALC: begin
               acc_r <= op_r[2] ? div_next_s : mul_next_s;
               cnt_r <= cnt_r - CNT_W'(1);
            end
            S_FIX: begin
               if (!flush) begin
                  result_r      <= fix_val_s;
                  div_by_zero_r <= dbz_r;
               end
            end
            default: begin
            end
         endcase
      end
   end

endmodule

// File: tb/tb_muldiv_unit.sv
// tb_muldiv_unit: directed and randomized checks of muldiv_unit against a 64-bit arithmetic model.
module tb_muldiv_unit;

   localparam int XLEN = 32;

   logic              clk = 1'b0;
   logic              rst_n = 1'b0;
   logic              flush = 1'b0;
   logic              in_valid = 1'b0;
   logic              in_ready;
   logic [2:0]        op_in = 3'b000;
   logic [XLEN-1:0]   a_in = '0;
   logic [XLEN-1:0]   b_in = '0;
   logic              out_valid;
   logic              out_ready = 1'b0;
   logic [XLEN-1:0]   result;
   logic              div_by_zero;

   int tests = 0;
   int fails = 0;

   muldiv_unit #(.XLEN(XLEN)) dut (
      .clk(clk), .rst_n(rst_n), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
      .op(op_in), .a(a_in), .b(b_in), .out_valid(out_valid), .out_ready(out_ready),
      .result(result), .div_by_zero(div_by_zero)
   );

   always #5 clk = ~clk;

   // Reference result computed with plain 64-bit arithmetic.
   function automatic logic [31:0] model(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
      longint          sa = longint'($signed(a));
      longint          sb = longint'($signed(b));
      longint unsigned ua = 64'(a);
      longint unsigned ub = 64'(b);
      logic [63:0]     p;
      case (op)
         3'd0: begin p = ua * ub; return p[31:0]; end
         3'd1: begin p = sa * sb; return p[63:32]; end
         3'd2: begin p = sa * longint'(ub); return p[63:32]; end
         3'd3: begin p = ua * ub; return p[63:32]; end
         3'd4: begin if (b == 32'd0) return 32'hFFFF_FFFF; p = sa / sb; return p[31:0]; end
         3'd5: begin if (b == 32'd0) return 32'hFFFF_FFFF; p = ua / ub; return p[31:0]; end
         3'd6: begin if (b == 32'd0) return a; p = sa % sb; return p[31:0]; end
         default: begin if (b == 32'd0) return a; p = ua % ub; return p[31:0]; end
      endcase
   endfunction

   function automatic int spec_lat(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
      if (op[2] && b == 32'd0) return 1;
      if ((op == 3'd4 || op == 3'd6) && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 1;
      return XLEN + 1;
   endfunction

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
      end
   endtask

   task automatic start_op(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
      @(negedge clk);
      op_in = op; a_in = a; b_in = b; in_valid = 1'b1;
      check("in_ready_before_accept", {31'd0, in_ready}, 32'd1);
      @(posedge clk);
      #1;
      in_valid = 1'b0;
   endtask

   task automatic wait_done(output int lat);
      lat = 0;
      do begin
         @(posedge clk);
         #1;
         lat++;
      end while (out_valid !== 1'b1 && lat < 100);
   endtask

   task automatic consume();
      out_ready = 1'b1;
      @(posedge clk);
      #1;
      out_ready = 1'b0;
      check("out_valid_after_handshake", {31'd0, out_valid}, 32'd0);
      check("in_ready_after_handshake", {31'd0, in_ready}, 32'd1);
   endtask

   task automatic do_op(input string tag, input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] exp_res, input logic exp_dbz, input int exp_lat);
      int lat;
      start_op(op, a, b);
      wait_done(lat);
      check({tag, "_latency"}, 32'(lat), 32'(exp_lat));
      check({tag, "_result"}, result, exp_res);
      check({tag, "_dbz"}, {31'd0, div_by_zero}, {31'd0, exp_dbz});
      consume();
   endtask

   initial begin
      int          lat;
      int          seen;
      logic [2:0]  rop;
      logic [31:0] ra, rb;

      // Reset state
      #1;
      check("reset_in_ready", {31'd0, in_ready}, 32'd1);
      check("reset_out_valid", {31'd0, out_valid}, 32'd0);
      check("reset_result", result, 32'd0);
      check("reset_dbz", {31'd0, div_by_zero}, 32'd0);
      @(negedge clk);
      @(negedge clk);
      rst_n = 1'b1;

      // Directed arithmetic cases
      do_op("mul_7_m3",     3'd0, 32'd7,          32'hFFFF_FFFD, 32'hFFFF_FFEB, 1'b0, 33);
      do_op("mulh_min_min", 3'd1, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 1'b0, 33);
      do_op("mulhu_ones",   3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 1'b0, 33);
      do_op("mulhsu_m1",    3'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, 33);
      do_op("div_m7_2",     3'd4, 32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFD, 1'b0, 33);
      do_op("rem_m7_2",     3'd6, 32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFF, 1'b0, 33);
      do_op("divu_100_7",   3'd5, 32'd100,       32'd7,         32'd14,        1'b0, 33);
      do_op("remu_100_7",   3'd7, 32'd100,       32'd7,         32'd2,         1'b0, 33);

      // Special cases
      do_op("divu_by0",     3'd5, 32'd5,         32'd0,         32'hFFFF_FFFF, 1'b1, 1);
      do_op("rem_by0",      3'd6, 32'd5,         32'd0,         32'd5,         1'b1, 1);
      do_op("div_ovf",      3'd4, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 1'b0, 1);
      do_op("rem_ovf",      3'd6, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0,         1'b0, 1);

      // Backpressure: result held for 10 cycles
      start_op(3'd0, 32'd1234, 32'd5678);
      wait_done(lat);
      for (int i = 0; i < 10; i++) begin
         @(posedge clk);
         #1;
         check("bp_out_valid", {31'd0, out_valid}, 32'd1);
         check("bp_result", result, 32'd7006652);
      end
      consume();

      // in_valid during CALC is ignored
      start_op(3'd5, 32'd100, 32'd7);
      repeat (3) begin @(posedge clk); #1; end
      op_in = 3'd0; a_in = 32'd3; b_in = 32'd3; in_valid = 1'b1;
      check("calc_in_ready", {31'd0, in_ready}, 32'd0);
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      wait_done(lat);
      check("calc_ignore_latency", 32'(lat), 32'(XLEN + 1 - 4));
      check("calc_ignore_result", result, 32'd14);
      consume();

      // Flush at CALC cycle 10
      start_op(3'd0, 32'd99, 32'd77);
      repeat (9) begin @(posedge clk); #1; end
      flush = 1'b1;
      @(posedge clk);
      #1;
      flush = 1'b0;
      check("flush_out_valid", {31'd0, out_valid}, 32'd0);
      check("flush_in_ready", {31'd0, in_ready}, 32'd1);
      seen = 0;
      for (int i = 0; i < XLEN + 5; i++) begin
         @(posedge clk);
         #1;
         if (out_valid === 1'b1) seen++;
      end
      check("flush_no_result", 32'(seen), 32'd0);
      do_op("after_flush", 3'd4, 32'hFFFF_FF9C, 32'd7, 32'hFFFF_FFF2, 1'b0, 33);

      // flush together with in_valid in IDLE does not accept
      @(negedge clk);
      op_in = 3'd0; a_in = 32'd2; b_in = 32'd2; in_valid = 1'b1; flush = 1'b1;
      @(posedge clk);
      #1;
      in_valid = 1'b0; flush = 1'b0;
      check("flush_idle_not_accepted", {31'd0, in_ready}, 32'd1);

      // Reset mid-CALC
      start_op(3'd1, 32'h1234_5678, 32'h9ABC_DEF0);
      repeat (5) begin @(posedge clk); #1; end
      rst_n = 1'b0;
      #1;
      check("rst_mid_in_ready", {31'd0, in_ready}, 32'd1);
      check("rst_mid_out_valid", {31'd0, out_valid}, 32'd0);
      check("rst_mid_result", result, 32'd0);
      check("rst_mid_dbz", {31'd0, div_by_zero}, 32'd0);
      @(negedge clk);
      rst_n = 1'b1;
      do_op("after_reset", 3'd7, 32'hFFFF_FFFF, 32'd10, 32'd5, 1'b0, 33);

      // Randomized operations against the reference model
      for (int i = 0; i < 40; i++) begin
         rop = 3'($urandom_range(0, 7));
         case ($urandom_range(0, 3))
            0:       ra = 32'h8000_0000;
            2:       ra = 32'($urandom_range(0, 20));
            default: ra = $urandom;
         endcase
         case ($urandom_range(0, 4))
            0:       rb = 32'd0;
            1:       rb = 32'hFFFF_FFFF;
            2:       rb = 32'($urandom_range(1, 20));
            default: rb = $urandom;
         endcase
         do_op("rand", rop, ra, rb, model(rop, ra, rb), rop[2] && (rb == 32'd0), spec_lat(rop, ra, rb));
      end

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
